// File: rtl/sync_filter.sv
// sync_filter: multi-channel asynchronous level synchroniser with an optional
// persistence filter and registered edge pulses. One instance can serve every
// asynchronous input of a block: buttons, switches, status pins or flags from
// another clock domain.
//
// Parameters
//   CHANNELS       number of independent channels
//   STAGES         synchroniser flop depth per channel (>= 2)
//   FILTER_CYCLES  cycles a new synchronised value must hold before dout
//                  accepts it (1 = no filtering)
//   RESET_VAL      per-channel reset value of chain flops and dout
//
// Ports
//   clk      system clock, rising edge
//   resetn   asynchronous active-low reset
//   din      asynchronous level inputs
//   dout     synchronised, filtered levels (registered)
//   rise     one-cycle pulse with the edge where dout[i] goes 0->1
//   fall     one-cycle pulse with the edge where dout[i] goes 1->0
//   changed  registered OR of all rise/fall bits
module sync_filter #(
   parameter int                  CHANNELS      = 4,
   parameter int                  STAGES        = 2,
   parameter int                  FILTER_CYCLES = 1,
   parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                changed
);

   localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_filter: STAGES must be at least 2");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("sync_filter: FILTER_CYCLES must be at least 1");
   end

   logic [CHANNELS-1:0] sync_lvl;
   logic [CHANNELS-1:0] upd;
   logic [CHANNELS-1:0] rise_nxt;
   logic [CHANNELS-1:0] fall_nxt;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
      logic [CNT_W-1:0] cnt;

      // Pure flop chain; nothing may sit between these stages.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            chain <= {STAGES{RESET_VAL[i]}};
         end else begin
            chain <= {chain[STAGES-2:0], din[i]};
         end
      end

      assign sync_lvl[i] = chain[STAGES-1];

      // Counts consecutive cycles the synchronised level disagrees with dout.
      // Any agreement clears it, so separate excursions never add up.
      assign upd[i] = (sync_lvl[i] != dout[i]) && (cnt == CNT_MAX);

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            cnt <= '0;
         end else if ((sync_lvl[i] == dout[i]) || (cnt == CNT_MAX)) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      rise_nxt = upd & sync_lvl;
      fall_nxt = upd & ~sync_lvl;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dout    <= RESET_VAL;
         rise    <= '0;
         fall    <= '0;
         changed <= 1'b0;
      end else begin
         dout    <= (dout & ~upd) | (sync_lvl & upd);
         rise    <= rise_nxt;
         fall    <= fall_nxt;
         changed <= |(rise_nxt | fall_nxt);
      end
   end

endmodule

// File: tb/tb_sync_filter.sv
// Bench for sync_filter: four instances with different depth/filter/reset
// settings, directed scenarios followed by random level changes and random
// resets, all compared every cycle against a history-window model.
module tb_sync_filter;

   localparam int               SP  [4] = '{2, 3, 2, 2};
   localparam int               FP  [4] = '{1, 1, 4, 8};
   localparam logic [3:0]       RVP [4] = '{4'b0101, 4'b0000, 4'b0000, 4'b1000};

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] din     [4];
   logic       rstn    [4];
   logic [3:0] dout    [4];
   logic [3:0] rise    [4];
   logic [3:0] fall    [4];
   logic       changed [4];

   logic [3:0] nxt_din  [4];
   logic       nxt_rstn [4];

   // model state: din value seen at each edge since the last reset release
   logic [3:0] hist     [4][$];
   logic [3:0] exp_dout [4];
   logic [3:0] exp_rise [4];
   logic [3:0] exp_fall [4];
   logic       exp_chg  [4];

   int total = 0;
   int bad   = 0;

   sync_filter #(.CHANNELS(4), .STAGES(2), .FILTER_CYCLES(1), .RESET_VAL(4'b0101)) u0 (
      .clk(clk), .resetn(rstn[0]), .din(din[0]), .dout(dout[0]),
      .rise(rise[0]), .fall(fall[0]), .changed(changed[0]));
   sync_filter #(.CHANNELS(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(4'b0000)) u1 (
      .clk(clk), .resetn(rstn[1]), .din(din[1]), .dout(dout[1]),
      .rise(rise[1]), .fall(fall[1]), .changed(changed[1]));
   sync_filter #(.CHANNELS(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(4'b0000)) u2 (
      .clk(clk), .resetn(rstn[2]), .din(din[2]), .dout(dout[2]),
      .rise(rise[2]), .fall(fall[2]), .changed(changed[2]));
   sync_filter #(.CHANNELS(4), .STAGES(2), .FILTER_CYCLES(8), .RESET_VAL(4'b1000)) u3 (
      .clk(clk), .resetn(rstn[3]), .din(din[3]), .dout(dout[3]),
      .rise(rise[3]), .fall(fall[3]), .changed(changed[3]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset(input int i);
      hist[i].delete();
      exp_dout[i] = RVP[i];
      exp_rise[i] = '0;
      exp_fall[i] = '0;
      exp_chg[i]  = 1'b0;
   endtask

   // dout flips at edge n when the synchroniser output seen before each of
   // the last F edges was the opposite of dout. The value seen before edge n
   // is the din captured at edge n-S (reset value if that predates release).
   task automatic model_edge(input int i);
      int         n;
      logic [3:0] upd;
      logic [3:0] e;
      logic       v;
      logic       all_diff;
      hist[i].push_back(din[i]);
      n   = hist[i].size();
      upd = '0;
      for (int ch = 0; ch < 4; ch++) begin
         all_diff = 1'b1;
         for (int k = n - SP[i] - FP[i]; k <= n - SP[i] - 1; k++) begin
            if (k < 0) begin
               e = RVP[i];
            end else begin
               e = hist[i][k];
            end
            v = e[ch];
            if (v == exp_dout[i][ch]) all_diff = 1'b0;
         end
         upd[ch] = all_diff;
      end
      exp_rise[i] = upd & ~exp_dout[i];
      exp_fall[i] = upd & exp_dout[i];
      exp_chg[i]  = |upd;
      exp_dout[i] = exp_dout[i] ^ upd;
   endtask

   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         din[i]  = nxt_din[i];
         rstn[i] = nxt_rstn[i];
         if (!nxt_rstn[i]) model_reset(i);
      end
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (rstn[i]) model_edge(i);
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("u%0d_dout", i), dout[i], exp_dout[i]);
         chk($sformatf("u%0d_rise", i), rise[i], exp_rise[i]);
         chk($sformatf("u%0d_fall", i), fall[i], exp_fall[i]);
         chk($sformatf("u%0d_changed", i), changed[i], exp_chg[i]);
      end
   endtask

   int         pulses;
   logic [3:0] rise_acc;
   logic [3:0] fall_acc;

   initial begin
      for (int i = 0; i < 4; i++) begin
         rstn[i] = 1'b0; nxt_rstn[i] = 1'b0;
         din[i]  = '0;   nxt_din[i]  = '0;
         model_reset(i);
      end

      // reset defaults on u0, latency on u1
      nxt_din[0] = 4'b1010;
      nxt_din[1] = 4'b0001;
      repeat (3) begin
         step();
         chk("rst_dout_u0", dout[0], 4'b0101);
         chk("rst_changed_u0", changed[0], 1'b0);
      end
      for (int i = 0; i < 4; i++) nxt_rstn[i] = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         if (e < 3) chk("pre_dout_u0", dout[0], 4'b0101);
         if (e == 3) begin
            chk("edge3_dout_u0", dout[0], 4'b1010);
            chk("edge3_rise_u0", rise[0], 4'b1010);
            chk("edge3_fall_u0", fall[0], 4'b0101);
            chk("edge3_changed_u0", changed[0], 1'b1);
            chk("edge3_dout_u1", dout[1][0], 1'b0);
         end
         if (e == 4) begin
            chk("edge4_rise_u0", rise[0], 4'b0000);
            chk("edge4_changed_u0", changed[0], 1'b0);
            chk("edge4_dout_u1", dout[1][0], 1'b1);
            chk("edge4_rise_u1", rise[1][0], 1'b1);
         end
         if (e == 5) chk("edge5_rise_u1", rise[1][0], 1'b0);
      end

      // glitch reject on u2: 3 cycles high never passes F=4
      nxt_din[2] = 4'b0001;
      for (int e = 1; e <= 9; e++) begin
         if (e == 4) nxt_din[2] = 4'b0000;
         step();
         chk("glitch_dout_u2", dout[2][0], 1'b0);
         chk("glitch_rise_u2", rise[2][0], 1'b0);
      end
      nxt_din[2] = 4'b0001;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (e == 5) chk("hold_e5_dout_u2", dout[2][0], 1'b0);
         if (e == 6) begin
            chk("hold_e6_dout_u2", dout[2][0], 1'b1);
            chk("hold_e6_rise_u2", rise[2][0], 1'b1);
         end
      end

      // interrupted count on u2 channel 2: high 3, low 1, then high
      for (int e = 1; e <= 13; e++) begin
         nxt_din[2][2] = (e != 4);
         step();
         chk("intr_rise_u2", rise[2][2], (e == 10));
      end

      // multi-channel on u0: one changed pulse per transition
      nxt_din[0] = 4'b0000;
      repeat (5) step();
      nxt_din[0] = 4'b1111;
      pulses = 0;
      repeat (5) begin
         step();
         pulses += int'(changed[0]);
      end
      chk("multi_up_pulses", pulses, 1);
      nxt_din[0] = 4'b0110;
      pulses = 0; rise_acc = '0; fall_acc = '0;
      repeat (5) begin
         step();
         pulses += int'(changed[0]);
         rise_acc |= rise[0];
         fall_acc |= fall[0];
      end
      chk("multi_dn_pulses", pulses, 1);
      chk("multi_dn_fall", fall_acc, 4'b1001);
      chk("multi_dn_rise", rise_acc, 4'b0000);

      // reset mid-count on u3 (F=8): count 5 reached, then reset
      nxt_din[3] = 4'b1010;
      repeat (7) step();
      nxt_rstn[3] = 1'b0;
      step();
      chk("midrst_dout_u3", dout[3], 4'b1000);
      nxt_rstn[3] = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         step();
         chk("midrst_rise_u3", rise[3][1], (e == 10));
      end

      // random levels and occasional resets
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
               if ($urandom_range(0, 3 * FP[i] + 2) == 0) nxt_din[i][ch] = ~nxt_din[i][ch];
            end
            nxt_rstn[i] = ($urandom_range(0, 299) != 0);
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_filter.md
Name: sync_filter

Overview:
- Parametrised multi-channel successor to the two-flop `sync` cell.
- Each channel carries an asynchronous level input into the `clk` domain through a configurable-depth flop chain.
- An optional per-channel glitch filter follows the chain, and each channel produces registered single-cycle rise/fall pulses.
- Used at every asynchronous boundary: buttons, switches, external status pins, cross-domain flags.

Parameters:
- CHANNELS, 4, number of independent channels (≥1).
- STAGES, 2, synchroniser flop depth per channel. Must be ≥2; elaboration error otherwise.
- FILTER_CYCLES, 1, consecutive cycles a new synchronised value must persist before `dout` accepts it. Must be ≥1; 1 = no filtering.
- RESET_VAL, {CHANNELS{1'b0}}, per-channel value loaded into all chain flops and `dout` on reset.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- din  input  CHANNELS  asynchronous level inputs; no timing relation to clk.
- dout  output  CHANNELS  synchronised, filtered levels (registered).
- rise  output  CHANNELS  one-cycle pulse, registered: dout[i] went 0→1 on this edge.
- fall  output  CHANNELS  one-cycle pulse, registered: dout[i] went 1→0 on this edge.
- changed  output  1  registered OR of all rise|fall bits.

Behaviour:

Reset:
- Asynchronous assert and deassert on resetn=0.
- Chain flops ← RESET_VAL; dout ← RESET_VAL; filter counters ← 0; rise/fall/changed ← 0.
- Reset mid-operation discards any pending filter count immediately. No pulses are generated by reset or by its release.

Synchroniser (per channel i):
- s[0] ← din[i]; s[k] ← s[k-1] for k = 1..STAGES-1.
- Let sync_i = s[STAGES-1]. No logic between chain flops.
- Chain flops carry an ASYNC_REG attribute.

Filter (per channel i):
- Counter cnt_i, width clog2(FILTER_CYCLES), minimum 1 bit.
- If sync_i == dout[i]: cnt_i ← 0.
- Else if cnt_i == FILTER_CYCLES-1: dout[i] ← sync_i; cnt_i ← 0.
- Else: cnt_i ← cnt_i + 1.
- A sync_i excursion shorter than FILTER_CYCLES cycles never reaches dout. Reverting early resets the count; counts do not accumulate across excursions.
- Counter never wraps; maximum value is FILTER_CYCLES-1.

Pulses:
- On the edge where dout[i] updates, rise[i] ← sync_i and fall[i] ← ~sync_i. Otherwise both ← 0.
- So rise[i] and fall[i] are high together with the new dout value for exactly one cycle.
- rise[i] and fall[i] are never both high.
- changed ← |(next rise | next fall), asserted in the same cycle as the pulses.

Latency:
- din[i] changes between edge 0 and edge 1 and stays stable.
- dout[i], rise/fall and changed reflect the change after edge STAGES+FILTER_CYCLES.
- Example: default STAGES=2, F=1 gives 3 edges.
- Metastability can add ±1 cycle in silicon; the bench models zero-delay flops.

Simultaneous events:
- Channels are fully independent; multiple channels may pulse in the same cycle.
- changed is a single pulse in that cycle.
- A channel can produce a new pulse at most once per FILTER_CYCLES cycles.

Test Plan:
- Reset defaults: CHANNELS=4, RESET_VAL=4'b0101, din=4'b1010 held, resetn low then released → dout=0101, no pulses, during reset. After release, dout=1010 at edge 3. rise[1], rise[3], fall[0], fall[2] and changed all high for that one cycle only.
- Latency: STAGES=3, F=1, din[0] 0→1 before edge 1 → dout[0]=1 and rise[0]=1 after edge 4. rise[0]=0 after edge 5.
- Glitch reject: STAGES=2, F=4, din[0] high for 3 cycles then low → dout[0] stays 0, no pulse. Held 4 cycles → dout[0]=1 after edge 6.
- Interrupted count: F=4, din[2] high 3 cycles, low 1, high 4 → single rise[2] only after the second excursion, 6 edges after it starts.
- Multi-channel: din 0000→1111 at once, then 1111→0110 → one changed pulse per transition. Second transition gives fall[0], fall[3] only.
- Reset mid-count: F=8, din[1] high, resetn pulsed low at count 5 → dout[1]=RESET_VAL[1], cnt cleared. After release a full 2+8 edges are needed before rise[1].
